// File: rtl/exe_stage.sv
// Execute stage: ID/EX latch, operand-2 former, ALU with NZCV status register, branch target.
// Define EXE_BARREL_SHIFT_EN to enable the LSL/LSR/ASR/ROR shifter on register-form operand 2.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic [3:0]  EXE_CMD_in,
  input  logic        imm_in,
  input  logic [11:0] Shift_operand_in,
  input  logic [23:0] Signed_imm_24_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn_in,
  input  logic [31:0] Val_Rm_in,
  input  logic [3:0]  Dest_in,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic [31:0] ALU_Res,
  output logic [31:0] Val_Rm_out,
  output logic [3:0]  Dest_out,
  output logic        Br_taken,
  output logic [31:0] Br_addr,
  output logic [3:0]  SR
);

  logic        wb_en_q, mem_r_en_q, mem_w_en_q, b_q, s_q, imm_q;
  logic [3:0]  exe_cmd_q, dest_q, sr_q, sr_next;
  logic [11:0] shift_op_q;
  logic [23:0] simm24_q;
  logic [31:0] pc_q, val_rn_q, val_rm_q;
  logic [31:0] val2, reg_val2, imm_val2, imm32, alu_res, add_b;
  logic [4:0]  imm_rot;
  logic [32:0] sum;
  logic        arith, logic_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      b_q        <= 1'b0;
      s_q        <= 1'b0;
      imm_q      <= 1'b0;
      exe_cmd_q  <= '0;
      shift_op_q <= '0;
      simm24_q   <= '0;
      pc_q       <= '0;
      val_rn_q   <= '0;
      val_rm_q   <= '0;
      dest_q     <= '0;
      sr_q       <= '0;
    end else begin
      if (flush || !freeze) begin
        wb_en_q    <= WB_EN_in    & ~flush;
        mem_r_en_q <= MEM_R_EN_in & ~flush;
        mem_w_en_q <= MEM_W_EN_in & ~flush;
        b_q        <= B_in        & ~flush;
        s_q        <= S_in        & ~flush;
        imm_q      <= imm_in;
        exe_cmd_q  <= EXE_CMD_in;
        shift_op_q <= Shift_operand_in;
        simm24_q   <= Signed_imm_24_in;
        pc_q       <= PC_in;
        val_rn_q   <= Val_Rn_in;
        val_rm_q   <= Val_Rm_in;
        dest_q     <= Dest_in;
      end
      // A frozen instruction has not finished EXE, so it must not re-apply its flags each stall cycle.
      if (s_q && (flush || !freeze))
        sr_q <= sr_next;
    end
  end

  assign imm32    = {24'b0, shift_op_q[7:0]};
  assign imm_rot  = {shift_op_q[11:8], 1'b0};
  assign imm_val2 = (imm32 >> imm_rot) | (imm32 << (6'd32 - {1'b0, imm_rot}));

`ifdef EXE_BARREL_SHIFT_EN
  logic [4:0] sh_amt;
  assign sh_amt = shift_op_q[11:7];

  always_comb begin
    reg_val2 = val_rm_q;
    if (sh_amt != 5'd0) begin
      case (shift_op_q[6:5])
        2'b00:   reg_val2 = val_rm_q << sh_amt;
        2'b01:   reg_val2 = val_rm_q >> sh_amt;
        2'b10:   reg_val2 = $unsigned($signed(val_rm_q) >>> sh_amt);
        default: reg_val2 = (val_rm_q >> sh_amt) | (val_rm_q << (6'd32 - {1'b0, sh_amt}));
      endcase
    end
  end
`else
  assign reg_val2 = val_rm_q;
`endif

  always_comb begin
    if (mem_r_en_q || mem_w_en_q) val2 = {20'b0, shift_op_q};
    else if (imm_q)               val2 = imm_val2;
    else                          val2 = reg_val2;
  end

  always_comb begin
    sum      = '0;
    add_b    = '0;
    alu_res  = '0;
    arith    = 1'b0;
    logic_op = 1'b0;
    sr_next  = sr_q;
    case (exe_cmd_q)
      4'b0001: begin alu_res = val2;             logic_op = 1'b1; end
      4'b1001: begin alu_res = ~val2;            logic_op = 1'b1; end
      4'b0110: begin alu_res = val_rn_q & val2;  logic_op = 1'b1; end
      4'b0111: begin alu_res = val_rn_q | val2;  logic_op = 1'b1; end
      4'b1000: begin alu_res = val_rn_q ^ val2;  logic_op = 1'b1; end
      4'b0010: begin add_b = val2;  sum = {1'b0, val_rn_q} + {1'b0, add_b};                     arith = 1'b1; end
      4'b0011: begin add_b = val2;  sum = {1'b0, val_rn_q} + {1'b0, add_b} + {32'b0, sr_q[1]};  arith = 1'b1; end
      4'b0100: begin add_b = ~val2; sum = {1'b0, val_rn_q} + {1'b0, add_b} + 33'd1;             arith = 1'b1; end
      4'b0101: begin add_b = ~val2; sum = {1'b0, val_rn_q} + {1'b0, add_b} + {32'b0, sr_q[1]};  arith = 1'b1; end
      default: ;
    endcase
    if (arith) begin
      alu_res = sum[31:0];
      sr_next = {alu_res[31], alu_res == 32'd0, sum[32],
                 (val_rn_q[31] == add_b[31]) && (alu_res[31] != val_rn_q[31])};
    end else if (logic_op) begin
      sr_next = {alu_res[31], alu_res == 32'd0, sr_q[1:0]};
    end
  end

  assign WB_EN      = wb_en_q;
  assign MEM_R_EN   = mem_r_en_q;
  assign MEM_W_EN   = mem_w_en_q;
  assign ALU_Res    = alu_res;
  assign Val_Rm_out = val_rm_q;
  assign Dest_out   = dest_q;
  assign Br_taken   = b_q;
  assign Br_addr    = pc_q + {{6{simm24_q[23]}}, simm24_q, 2'b00};
  assign SR         = sr_q;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage ARM-subset pipeline. It sits directly downstream of the decode stage's control unit and register file. It captures their outputs in an internal ID/EX latch and forms the second operand (immediate rotate or register shift). It runs the ALU selected by `EXE_CMD`, keeps the NZCV status register, computes the branch target, and presents results to the EX/MEM boundary.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  hold ID/EX latch (hazard stall).
- `flush`  in  1  load bubble into ID/EX latch (taken branch).
- `WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in`  in  1 each  decode control bits; `S_in` is the status-update request.
- `EXE_CMD_in`  in  4  ALU command.
- `imm_in`  in  1  operand 2 is rotated immediate.
- `Shift_operand_in`  in  12  instruction bits [11:0].
- `Signed_imm_24_in`  in  24  branch offset.
- `PC_in`  in  32  PC+4 of the decoded instruction.
- `Val_Rn_in, Val_Rm_in`  in  32 each  register-file operands.
- `Dest_in`  in  4  destination register.
- `WB_EN, MEM_R_EN, MEM_W_EN`  out  1 each  latched control bits to EX/MEM.
- `ALU_Res`  out  32  ALU result, or memory address for LDR/STR.
- `Val_Rm_out`  out  32  store data.
- `Dest_out`  out  4  latched destination.
- `Br_taken`  out  1  latched `B`.
- `Br_addr`  out  32  branch target.
- `SR`  out  4  status register {N,Z,C,V}.

## Operation
- **ID/EX latch**
  - Priority: `rst` > `flush` > `freeze` > load.
  - `flush` clears WB_EN, MEM_R_EN, MEM_W_EN, B and S (bubble); data fields may load.
  - `freeze` holds every field.
- **Operand 2 (Val2)**
  - If MEM_R_EN or MEM_W_EN is latched: {20'b0, Shift_operand[11:0]}, zero-extended offset.
  - Else if `imm`: {24'b0, Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
  - Else: Val_Rm shifted by Shift_operand[11:7]. Shift type in [6:5] is 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 means no shift for every type.
- **ALU (EXE_CMD)**
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+C
  - 0100 SUB: Rn−Val2
  - 0101 SBC: Rn−Val2−!C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0, flags unchanged.
- **Flags**
  - N = res[31]; Z = (res==0).
  - Arithmetic: C is the carry-out of the 33-bit sum. Subtraction is computed as Rn+~Val2+1 (SUB) or Rn+~Val2+C (SBC), so C=1 means no borrow.
  - V = signed overflow.
  - Logical ops and MOV/MVN: C and V unchanged.
- **SR** loads the new NZCV at the clock edge ending the EXE cycle, only when latched S=1.
- **Branch**
  - Br_addr = PC + (sign-extended Signed_imm_24 << 2), modulo 2^32.
  - Br_taken = latched B.
  - The upstream fetch/flush logic consumes both outputs.

## Timing
- Latency: one cycle from the decode inputs to valid `ALU_Res`/`Br_addr`. The outputs are combinational from the latch.
- SR updates one edge after the instruction enters EXE. The next instruction's ADC/SBC therefore sees the updated C with no forwarding.
- **Reset:** latch and SR all zero. Every output is 0 (WB_EN=MEM_R_EN=MEM_W_EN=Br_taken=0, ALU_Res=Br_addr=0, SR=4'b0000).
- **flush and freeze together:** flush wins and a bubble is inserted.
- **Bubble:** a bubble never writes SR and never asserts the memory or writeback enables.
- **Reset mid-stall:** clears the latch regardless of `freeze`.
- **Wrap-around:** arithmetic wraps modulo 2^32 with carry reported in C.

## Configuration
- `EXE_BARREL_SHIFT_EN` defined: register-form Val2 applies the full LSL/LSR/ASR/ROR shifter described above.
- Undefined: register-form Val2 = Val_Rm unshifted, and Shift_operand[11:5] is ignored.
- The immediate and memory-offset paths are unaffected in both cases.

## Test plan
- **Reset:** assert `rst` for 2 cycles with nonzero inputs → all outputs 0 and SR=0000.
- **ADD with S and carry:** Rn=0xFFFFFFFF, imm 0x01, EXE_CMD=0010, S=1 → ALU_Res=0; next cycle SR=0110 (Z,C).
- **SUB then SBC:** CMP-style SUB Rn=5, Val2=7, S=1 → SR=1000 (N, borrow). Following SBC Rn=10, Val2=2 → 7.
- **Immediate rotate:** imm=1, Shift_operand=0x4FF → Val2=0xFF000000; MOV gives ALU_Res=0xFF000000.
- **Shifter, macro on:** Rm=0x80000000 with ASR #4 → 0xF8000000. Macro off → 0x80000000.
- **Branch and hazards:**
  - PC=0x100, imm24=0xFFFFFE, B=1 → Br_addr=0xF8, Br_taken=1.
  - `flush` in the same cycle as `freeze` → next cycle all enables 0 and SR unchanged.
  - `freeze` for 3 cycles → outputs stable.
